serial_chunk_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder: A + B + Cin, computed CHUNK bits per clock through a

---
 rtl/serial_chunk_adder_pkg.sv | 20 ++
 rtl/serial_chunk_adder_chunk.sv | 35 +++
 rtl/serial_chunk_adder.sv | 114 +++++++++++
 tb/tb_serial_chunk_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: 2-bit FSM state constants (IDLE/RUN/DONE) and an elaboration-time clog2.
package serial_chunk_adder_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Ceiling log2, usable in parameter/localparam expressions.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value)
         r++;
      return r;
   endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// Latency: purely combinational, no registers.
// Backpressure: none; always evaluates its inputs.
// Ports: a, b   - CHUNK-bit addends
//        ci     - carry into bit 0
//        s      - CHUNK-bit sum
//        co     - carry out of the top bit
//        c_msb  - carry into the top bit (for signed overflow detection)
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign co    = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder (a + b + cin), CHUNK bits per clock via a registered carry.
// Latency: accept edge, then WIDTH/CHUNK compute edges; out_valid in the cycle after the last.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no pop+accept overlap.
// Ports: clk, rst (sync, active high)
//        in_valid/in_ready, a, b, cin     - operand handshake
//        out_valid/out_ready, sum, cout   - result handshake; sum mod 2^WIDTH
//        ovf                              - signed overflow (carry into MSB xor cout)
module serial_chunk_adder
   import serial_chunk_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = clog2(NCHUNK) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic [CHUNK-1:0] s_sl;
   logic             co;
   logic             c_msb;

   // The counter is kept in 0..NCHUNK-1 so these selects never go out of range,
   // even in IDLE/DONE where the adder output is simply ignored.
   assign a_sl = a_q[int'(cnt)*CHUNK +: CHUNK];
   assign b_sl = b_q[int'(cnt)*CHUNK +: CHUNK];

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_sl),
      .b     (b_sl),
      .ci    (carry_q),
      .s     (s_sl),
      .co    (co),
      .c_msb (c_msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  cnt     <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q[int'(cnt)*CHUNK +: CHUNK] <= s_sl;
               carry_q <= co;
               if (cnt == LAST_IDX) begin
                  // Last chunk holds the MSB: its carry-in/carry-out give ovf.
                  cout_q <= co;
                  ovf_q  <= c_msb ^ co;
                  cnt    <= '0;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench for serial_chunk_adder: a 16/4 instance and a 4/1 instance.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_chunk_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // WIDTH=16, CHUNK=4 instance
   logic        iv16, ir16, ov16, or16, cin16, co16, ovf16;
   logic [15:0] a16, b16, s16;
   // WIDTH=4, CHUNK=1 instance
   logic        iv4, ir4, ovl4, or4, cin4, co4, ovf4;
   logic [3:0]  a4, b4, s4;

   serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
      .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(ovf16));

   serial_chunk_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
      .out_valid(ovl4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(ovf4));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t vt[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed overflow from the signed range.
   function automatic void model(input int w, input logic [15:0] ta, input logic [15:0] tb,
                                 input logic tcin, output logic [15:0] es,
                                 output logic ec, output logic ev);
      int unsigned tot;
      int sa, sb, ss;
      int unsigned mask;
      mask = (32'd1 << w) - 1;
      tot  = (int'(ta) & mask) + (int'(tb) & mask) + int'(tcin);
      es   = 16'(tot & mask);
      ec   = tot[w];
      sa   = ta[w-1] ? (int'(ta) & mask) - (1 << w) : (int'(ta) & mask);
      sb   = tb[w-1] ? (int'(tb) & mask) - (1 << w) : (int'(tb) & mask);
      ss   = sa + sb + int'(tcin);
      ev   = (ss > (1 << (w-1)) - 1) || (ss < -(1 << (w-1)));
   endfunction

   // Issue one op, wait for its result, pop it. lat = cycles from accept cycle to out_valid.
   task automatic run_op(input bit w4, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tcin, output logic [15:0] rs, output logic rc,
                         output logic rv, output int lat);
      int n;
      n = 0;
      while (!(w4 ? ir4 : ir16) && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (w4) begin iv4 = 1'b1; a4 = ta[3:0]; b4 = tb[3:0]; cin4 = tcin; end
      else    begin iv16 = 1'b1; a16 = ta; b16 = tb; cin16 = tcin; end
      @(posedge clk); #1;
      iv4 = 1'b0; iv16 = 1'b0;
      lat = 1;
      while (!(w4 ? ovl4 : ov16) && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      if (w4) begin rs = {12'h000, s4}; rc = co4; rv = ovf4; or4 = 1'b1; end
      else    begin rs = s16; rc = co16; rv = ovf16; or16 = 1'b1; end
      @(posedge clk); #1;
      or4 = 1'b0; or16 = 1'b0;
   endtask

   initial begin
      logic [15:0] rs, es;
      logic        rc, rv, ec, ev;
      int          lat, cnt;

      vt[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
      vt[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vt[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vt[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vt[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[7] = '{16'h0FFF, 16'h0001, 1'b1, 16'h1001, 1'b0, 1'b0};

      rst = 1'b1;
      iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
      iv4  = 1'b0; or4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", ov16, 1'b0);
      check("reset in_ready", ir16, 1'b1);
      check("reset sum", s16, 16'h0000);
      check("reset cout", co16, 1'b0);
      check("reset ovf", ovf16, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("in_ready after reset", ir16, 1'b1);

      // Directed vectors on the 16/4 instance
      for (int i = 0; i < 8; i++) begin
         run_op(1'b0, vt[i].a, vt[i].b, vt[i].cin, rs, rc, rv, lat);
         check($sformatf("vec%0d sum", i), rs, vt[i].sum);
         check($sformatf("vec%0d cout", i), rc, vt[i].cout);
         check($sformatf("vec%0d ovf", i), rv, vt[i].ovf);
         check($sformatf("vec%0d latency", i), lat, 5);
      end

      // Backpressure: DONE held 10 cycles with new operands offered
      iv16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0;
      @(posedge clk); #1;
      iv16 = 1'b0;
      cnt = 0;
      while (!ov16 && cnt < 50) begin @(posedge clk); #1; cnt++; end
      check("bp reached done", ov16, 1'b1);
      iv16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1; or16 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp out_valid", ov16, 1'b1);
         check("bp in_ready", ir16, 1'b0);
         check("bp sum", s16, 16'h3333);
         check("bp cout", co16, 1'b0);
         check("bp ovf", ovf16, 1'b0);
      end
      iv16 = 1'b0; or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
      check("bp pop out_valid", ov16, 1'b0);
      check("bp pop in_ready", ir16, 1'b1);
      check("bp idle sum held", s16, 16'h3333);
      run_op(1'b0, 16'h0002, 16'h0003, 1'b0, rs, rc, rv, lat);
      check("bp next op sum", rs, 16'h0005);

      // Reset at the second compute edge of an op
      iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
      @(posedge clk); #1;           // E0 accept
      iv16 = 1'b0;
      @(posedge clk); #1;           // E1
      rst = 1'b1;
      @(posedge clk); #1;           // E2 under reset
      rst = 1'b0;
      check("abort out_valid", ov16, 1'b0);
      check("abort in_ready", ir16, 1'b1);
      check("abort sum", s16, 16'h0000);
      check("abort cout", co16, 1'b0);
      check("abort ovf", ovf16, 1'b0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ov16) cnt++;
      end
      check("abort no out_valid", cnt, 0);

      // Random ops on the 16/4 instance
      for (int i = 0; i < 20; i++) begin
         logic [15:0] ra, rb;
         logic        rcin;
         ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom);
         model(16, ra, rb, rcin, es, ec, ev);
         run_op(1'b0, ra, rb, rcin, rs, rc, rv, lat);
         check("rand sum", rs, es);
         check("rand cout", rc, ec);
         check("rand ovf", rv, ev);
      end

      // Exhaustive WIDTH=4, CHUNK=1
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               model(4, 16'(ia), 16'(ib), 1'(ic), es, ec, ev);
               run_op(1'b1, 16'(ia), 16'(ib), 1'(ic), rs, rc, rv, lat);
               check("w4 cout_sum", {rc, rs[3:0]}, {ec, es[3:0]});
               check("w4 ovf", rv, ev);
               check("w4 latency", lat, 5);
            end
         end
      end

      // Streaming: in_valid and out_ready held high, 8 random ops
      begin
         logic [15:0] sa[8], sb[8];
         logic        sc[8];
         int issued, rcv, last_pulse, cyc;
         bit rdy_before;
         for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom); sb[i] = 16'($urandom); sc[i] = 1'($urandom);
         end
         issued = 0; rcv = 0; last_pulse = -1; cyc = 0;
         or16 = 1'b1; iv16 = 1'b1; a16 = sa[0]; b16 = sb[0]; cin16 = sc[0];
         while (rcv < 8 && cyc < 200) begin
            rdy_before = ir16;
            @(posedge clk); #1;
            cyc++;
            if (rdy_before && iv16) begin
               issued++;
               if (issued < 8) begin
                  a16 = sa[issued]; b16 = sb[issued]; cin16 = sc[issued];
               end else begin
                  iv16 = 1'b0;
               end
            end
            if (ov16) begin
               model(16, sa[rcv], sb[rcv], sc[rcv], es, ec, ev);
               check($sformatf("stream%0d sum", rcv), s16, es);
               check($sformatf("stream%0d cout", rcv), co16, ec);
               check($sformatf("stream%0d ovf", rcv), ovf16, ev);
               if (last_pulse >= 0)
                  check("stream gap", cyc - last_pulse, 6);
               last_pulse = cyc;
               rcv++;
            end
         end
         check("stream count", rcv, 8);
         iv16 = 1'b0; or16 = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
